// File: rtl/div_pkg.sv
// Shared types and constants for the divide dispatch front end.
package div_pkg;

    localparam int DIV_XLEN  = 64;
    localparam int DIV_TAG_W = 6;

    typedef struct packed {
        logic                 is_signed;
        logic [DIV_XLEN-1:0]  dividend;
        logic [DIV_XLEN-1:0]  divisor;
        logic [DIV_TAG_W-1:0] tag;
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESULT
    } div_state_t;

    localparam logic [DIV_XLEN-1:0] DIV_ZERO_RESULT = '1;
    localparam logic [DIV_XLEN-1:0] DIV_INT_MIN     = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/div_op_fifo.sv
// Small op queue between the reservation station and the divider; flush empties it.
module div_op_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    input  logic    push,
    input  logic    pop,
    input  div_op_t din,
    output div_op_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    div_op_t        mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/div_dispatch.sv
// Issue-side front end for the iterative divider: queue, dispatch, result to CDB, flush.
// Define DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow without the divider.
module div_dispatch
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic             issue_signed_i,
    input  logic [XLEN-1:0]  issue_dividend_i,
    input  logic [XLEN-1:0]  issue_divisor_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    output logic             div_valid_o,
    input  logic             div_ready_i,
    output logic             div_signed_o,
    output logic [XLEN-1:0]  div_dividend_o,
    output logic [XLEN-1:0]  div_divisor_o,
    input  logic             div_valid_i,
    input  logic [XLEN-1:0]  div_quotient_i,
    output logic             div_yumi_o,
    output logic             cdb_valid_o,
    input  logic             cdb_ready_i,
    output logic [TAG_W-1:0] cdb_tag_o,
    output logic [XLEN-1:0]  cdb_data_o
);

    div_state_t       state, state_n;
    logic             squash, squash_n;
    logic [TAG_W-1:0] tag_q, tag_n;
    logic [XLEN-1:0]  data_q, data_n;
    div_op_t          in_op, head;
    logic             full, empty, pop;
    logic             fast;
    logic [XLEN-1:0]  fast_val;

    assign in_op = '{is_signed: issue_signed_i, dividend: issue_dividend_i,
                     divisor: issue_divisor_i, tag: issue_tag_i};

    div_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_i),
        .push  (issue_valid_i),
        .pop   (pop),
        .din   (in_op),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign issue_ready_o  = !full;
    assign div_signed_o   = head.is_signed;
    assign div_dividend_o = head.dividend;
    assign div_divisor_o  = head.divisor;
    assign cdb_tag_o      = tag_q;
    assign cdb_data_o     = data_q;

`ifdef DIV_FASTPATH_EN
    always_comb begin
        fast     = 1'b0;
        fast_val = DIV_ZERO_RESULT;
        if (head.divisor == '0) begin
            fast = 1'b1;
        end else if (head.is_signed && head.dividend == DIV_INT_MIN &&
                     head.divisor == DIV_ZERO_RESULT) begin
            fast     = 1'b1;
            fast_val = DIV_INT_MIN;
        end
    end
`else
    assign fast     = 1'b0;
    assign fast_val = '0;
`endif

    always_comb begin
        state_n     = state;
        squash_n    = squash;
        tag_n       = tag_q;
        data_n      = data_q;
        pop         = 1'b0;
        div_valid_o = 1'b0;
        div_yumi_o  = 1'b0;
        cdb_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                // A flushed head must not start a divide in the flush cycle.
                if (!empty && !flush_i) begin
                    if (fast) begin
                        pop     = 1'b1;
                        tag_n   = head.tag;
                        data_n  = fast_val;
                        state_n = S_RESULT;
                    end else begin
                        div_valid_o = 1'b1;
                        if (div_ready_i) begin
                            pop     = 1'b1;
                            tag_n   = head.tag;
                            state_n = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                div_yumi_o = div_valid_i;
                if (div_valid_i) begin
                    squash_n = 1'b0;
                    if (squash || flush_i) begin
                        state_n = S_IDLE;
                    end else begin
                        data_n  = div_quotient_i;
                        state_n = S_RESULT;
                    end
                end else if (flush_i) begin
                    squash_n = 1'b1;
                end
            end
            S_RESULT: begin
                cdb_valid_o = 1'b1;
                if (cdb_ready_i || flush_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            squash <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            squash <= squash_n;
            tag_q  <= tag_n;
            data_q <= data_n;
        end
    end

endmodule

// File: tb/tb_div_dispatch.sv
// Directed bench for div_dispatch with a behavioural RISC-V divider model.
module tb_div_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic        issue_signed_i;
    logic [63:0] issue_dividend_i;
    logic [63:0] issue_divisor_i;
    logic [5:0]  issue_tag_i;
    logic        div_valid_o;
    logic        div_ready_i;
    logic        div_signed_o;
    logic [63:0] div_dividend_o;
    logic [63:0] div_divisor_o;
    logic        div_valid_i;
    logic [63:0] div_quotient_i;
    logic        div_yumi_o;
    logic        cdb_valid_o;
    logic        cdb_ready_i;
    logic [5:0]  cdb_tag_o;
    logic [63:0] cdb_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_dispatch dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_signed_i   (issue_signed_i),
        .issue_dividend_i (issue_dividend_i),
        .issue_divisor_i  (issue_divisor_i),
        .issue_tag_i      (issue_tag_i),
        .div_valid_o      (div_valid_o),
        .div_ready_i      (div_ready_i),
        .div_signed_o     (div_signed_o),
        .div_dividend_o   (div_dividend_o),
        .div_divisor_o    (div_divisor_o),
        .div_valid_i      (div_valid_i),
        .div_quotient_i   (div_quotient_i),
        .div_yumi_o       (div_yumi_o),
        .cdb_valid_o      (cdb_valid_o),
        .cdb_ready_i      (cdb_ready_i),
        .cdb_tag_o        (cdb_tag_o),
        .cdb_data_o       (cdb_data_o)
    );

    // Behavioural divider: one op at a time, result after lat cycles, held until yumi.
    int   lat        = 3;
    bit   hold_ready = 1'b0;
    logic busy;
    int   cnt;
    int   hs_cnt     = 0;
    int   yumi_cnt   = 0;

    assign div_ready_i = !busy && !hold_ready;

    function automatic logic [63:0] ref_div(input logic s, input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (s) begin
            if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
            return $signed(a) / $signed(b);
        end
        return a / b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy           <= 1'b0;
            div_valid_i    <= 1'b0;
            cnt            <= 0;
            div_quotient_i <= '0;
        end else if (!busy) begin
            if (div_valid_o && div_ready_i) begin
                busy           <= 1'b1;
                cnt            <= lat;
                div_quotient_i <= ref_div(div_signed_o, div_dividend_o, div_divisor_o);
                hs_cnt         <= hs_cnt + 1;
            end
        end else if (div_valid_i) begin
            if (div_yumi_o) begin
                busy        <= 1'b0;
                div_valid_i <= 1'b0;
                yumi_cnt    <= yumi_cnt + 1;
            end
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else begin
            div_valid_i <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic do_issue(input logic s, input logic [63:0] a, input logic [63:0] b,
                            input logic [5:0] tag, output bit acc);
        @(negedge clk);
        issue_valid_i    = 1'b1;
        issue_signed_i   = s;
        issue_dividend_i = a;
        issue_divisor_i  = b;
        issue_tag_i      = tag;
        acc              = issue_ready_o;
        @(posedge clk);
        #1 issue_valid_i = 1'b0;
    endtask

    task automatic wait_cdb(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cdb_valid_o) break;
        end
        check(name, cdb_valid_o, 1);
    endtask

    task automatic consume();
        @(negedge clk);
        cdb_ready_i = 1'b1;
        @(posedge clk);
        #1 cdb_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        bit seen_res, seen_cdb;
        int hs0, y0;
        reset = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_signed_i = 1'b0;
        issue_dividend_i = '0; issue_divisor_i = '0; issue_tag_i = '0; cdb_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_issue_ready", issue_ready_o, 1);
        check("rst_div_valid", div_valid_o, 0);
        check("rst_yumi", div_yumi_o, 0);
        check("rst_cdb_valid", cdb_valid_o, 0);
        check("rst_cdb_tag", cdb_tag_o, 0);
        check("rst_cdb_data", cdb_data_o, 0);

        // Unsigned 100/7
        hs0 = hs_cnt; y0 = yumi_cnt;
        do_issue(0, 64'd100, 64'd7, 6'd3, acc);
        check("u100_acc", acc, 1);
        wait_cdb("u100_valid");
        check("u100_tag", cdb_tag_o, 3);
        check("u100_data", cdb_data_o, 14);
        repeat (2) @(negedge clk);
        check("u100_hold_valid", cdb_valid_o, 1);
        check("u100_hold_data", cdb_data_o, 14);
        consume();
        @(negedge clk);
        check("u100_released", cdb_valid_o, 0);
        check("u100_dispatch_cnt", hs_cnt - hs0, 1);
        check("u100_yumi_cnt", yumi_cnt - y0, 1);

        // Divide by zero
        hs0 = hs_cnt;
        do_issue(0, 64'd7, 64'd0, 6'd5, acc);
`ifdef DIV_FASTPATH_EN
        @(negedge clk);
        check("dz_n1_valid", cdb_valid_o, 0);
        @(negedge clk);
        check("dz_n2_valid", cdb_valid_o, 1);
        check("dz_no_dispatch", hs_cnt - hs0, 0);
`else
        wait_cdb("dz_valid");
`endif
        check("dz_tag", cdb_tag_o, 5);
        check("dz_data", cdb_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        consume();

        // Signed overflow
        do_issue(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd9, acc);
        wait_cdb("ovf_valid");
        check("ovf_tag", cdb_tag_o, 9);
        check("ovf_data", cdb_data_o, 64'h8000_0000_0000_0000);
        consume();

        // Back-pressure: divider busy, FIFO fills at two
        hold_ready = 1'b1;
        hs0 = hs_cnt;
        do_issue(1, 64'hFFFF_FFFF_FFFF_FFCE, 64'd5, 6'd10, acc);
        check("bp_acc1", acc, 1);
        do_issue(1, 64'd50, 64'hFFFF_FFFF_FFFF_FFFB, 6'd11, acc);
        check("bp_acc2", acc, 1);
        do_issue(1, 64'hFFFF_FFFF_FFFF_FFCE, 64'hFFFF_FFFF_FFFF_FFFB, 6'd12, acc);
        check("bp_acc3", acc, 0);
        check("bp_offer", div_valid_o, 1);
        check("bp_no_dispatch", hs_cnt - hs0, 0);
        hold_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_issue(1, 64'hFFFF_FFFF_FFFF_FFCE, 64'hFFFF_FFFF_FFFF_FFFB, 6'd12, acc);
            if (acc) break;
        end
        check("bp_acc3_retry", acc, 1);
        wait_cdb("bp1_valid");
        check("bp1_tag", cdb_tag_o, 10);
        check("bp1_data", cdb_data_o, 64'hFFFF_FFFF_FFFF_FFF6);
        consume();
        wait_cdb("bp2_valid");
        check("bp2_tag", cdb_tag_o, 11);
        check("bp2_data", cdb_data_o, 64'hFFFF_FFFF_FFFF_FFF6);
        consume();
        wait_cdb("bp3_valid");
        check("bp3_tag", cdb_tag_o, 12);
        check("bp3_data", cdb_data_o, 10);
        consume();

        // Flush while waiting on the divider, with a second op queued
        lat = 6;
        hs0 = hs_cnt;
        do_issue(0, 64'd20, 64'd4, 6'd20, acc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hs_cnt != hs0) break;
        end
        check("fl_dispatched", hs_cnt - hs0, 1);
        do_issue(0, 64'd30, 64'd3, 6'd21, acc);
        check("fl_queued_acc", acc, 1);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        seen_res = 1'b0; seen_cdb = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (div_valid_i) begin
                seen_res = 1'b1;
                check("fl_yumi", div_yumi_o, 1);
            end
            if (cdb_valid_o) seen_cdb = 1'b1;
        end
        check("fl_result_drained", seen_res, 1);
        check("fl_no_cdb", seen_cdb, 0);
        check("fl_fifo_empty", div_valid_o, 0);
        check("fl_issue_ready", issue_ready_o, 1);
        check("fl_queued_dropped", hs_cnt - hs0, 1);
        lat = 3;
        do_issue(1, 64'd50, 64'd5, 6'd22, acc);
        wait_cdb("fl_next_valid");
        check("fl_next_tag", cdb_tag_o, 22);
        check("fl_next_data", cdb_data_o, 10);
        consume();

        // Flush while presenting a result
        do_issue(0, 64'd9, 64'd3, 6'd7, acc);
        wait_cdb("flr_valid");
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("flr_cdb_dropped", cdb_valid_o, 0);

        // Reset while presenting a result
        do_issue(0, 64'd81, 64'd9, 6'd8, acc);
        wait_cdb("rr_valid");
        check("rr_data", cdb_data_o, 9);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rr_cdb_valid", cdb_valid_o, 0);
        check("rr_issue_ready", issue_ready_o, 1);
        check("rr_cdb_data", cdb_data_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
